// File: rtl/aes_dec_pkg.sv
// Shared AES-128 decryption types, tables and GF(2^8) helpers.
// Imported by the decryptor top, its round datapath and its port interface.
package aes_dec_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        ADDKEY,
        ROUND
    } state_e;

    // Index 0 is unused; rcon[1..10] follow.
    localparam logic [8*11-1:0] RCON_TBL = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Byte b of each table lives at bits [8*(255-b) +: 8].
    localparam logic [8*256-1:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [8*256-1:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[8*(255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[8*(255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        if (idx > 4'd10) return 8'h00;
        return RCON_TBL[8*(10 - int'(idx)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_decrypt_if.sv
// Start/done request bus of the AES-128 decryptor: 128-bit key and ciphertext in, plaintext out.
// master drives the request; slave is the decryptor.
interface aes_decrypt_if;
    import aes_dec_pkg::*;

    logic             start;
    logic [KEY_W-1:0] key;
    logic [KEY_W-1:0] data;
    logic [KEY_W-1:0] out;
    logic             done;
    logic             busy;

    modport master (output start, key, data, input out, done, busy);
    modport slave  (input start, key, data, output out, done, busy);

endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless last_round_i. Zero latency, no flow control.
module aes_inv_round
    import aes_dec_pkg::*;
(
    input  logic [KEY_W-1:0] state_i,
    input  logic [KEY_W-1:0] rkey_i,
    input  logic             last_round_i,
    output logic [KEY_W-1:0] state_o
);

    logic [KEY_W-1:0] t;
    logic [KEY_W-1:0] mix;

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
                gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
                gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
                gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
    endfunction

    // Byte (r,c) sits at index 4c+r; row r takes its byte from column (c-r) mod 4.
    always_comb begin
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[KEY_W-1-8*(4*c+r) -: 8] =
                    inv_sbox(state_i[KEY_W-1-8*(4*((c-r+4)%4)+r) -: 8]) ^
                    rkey_i[KEY_W-1-8*(4*c+r) -: 8];
            end
        end
    end

    always_comb begin
        mix = '0;
        for (int c = 0; c < 4; c++) begin
            mix[KEY_W-1-32*c -: 32] = inv_mix_col(t[KEY_W-1-32*c -: 32]);
        end
    end

    assign state_o = last_round_i ? t : mix;

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-128 decryptor, one round per clk: 21 clocks start-to-done (11 on a key hit when AES_DEC_KEY_CACHE_EN).
// No queueing: start is ignored while busy; done pulses one cycle and out holds until the next done.
module aes_decrypt
    import aes_dec_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    aes_decrypt_if.slave bus
);

    state_e           fsm_q, fsm_d;
    logic [KEY_W-1:0] state_q, state_d;
    logic [KEY_W-1:0] rkey_q, rkey_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [KEY_W-1:0] out_q, out_d;
    logic             done_q, done_d;

    logic [31:0]      w0, w1, w2, w3, w3_rev;
    logic [31:0]      sw_in, sw_out, tw;
    logic [31:0]      f0, f1, f2, f3;
    logic [3:0]       rc_idx;
    logic [KEY_W-1:0] key_fwd, key_rev, round_out;
    logic             last_rnd;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [KEY_W-1:0] lkey_q, lkey_d;
    logic [KEY_W-1:0] k10_q, k10_d;
    logic             cvld_q, cvld_d;
    logic             cache_hit;

    assign cache_hit = cvld_q && (bus.key == lkey_q);
`endif

    // Forward and reverse key steps share one SubWord; only its input word differs.
    assign {w0, w1, w2, w3} = rkey_q;
    assign w3_rev = w3 ^ w2;
    assign sw_in  = (fsm_q == EXPAND) ? w3 : w3_rev;
    assign sw_out = {sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0]), sbox(sw_in[31:24])};
    assign rc_idx = (fsm_q == ADDKEY) ? 4'(NR) : cnt_q;
    assign tw     = sw_out ^ {rcon(rc_idx), 24'h0};

    assign f0      = w0 ^ tw;
    assign f1      = w1 ^ f0;
    assign f2      = w2 ^ f1;
    assign f3      = w3 ^ f2;
    assign key_fwd = {f0, f1, f2, f3};
    assign key_rev = {w0 ^ tw, w1 ^ w0, w2 ^ w1, w3_rev};

    assign last_rnd = (cnt_q == 4'd0);

    aes_inv_round u_round (
        .state_i      (state_q),
        .rkey_i       (rkey_q),
        .last_round_i (last_rnd),
        .state_o      (round_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rkey_d  = rkey_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
        lkey_d  = lkey_q;
        k10_d   = k10_q;
        cvld_d  = cvld_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = bus.data;
                    cnt_d   = 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
                    if (cache_hit) begin
                        rkey_d = k10_q;
                        fsm_d  = ADDKEY;
                    end else begin
                        // Entry stays invalid until this key's K10 is known.
                        rkey_d = bus.key;
                        lkey_d = bus.key;
                        cvld_d = 1'b0;
                        fsm_d  = EXPAND;
                    end
`else
                    rkey_d = bus.key;
                    fsm_d  = EXPAND;
`endif
                end
            end
            EXPAND: begin
                rkey_d = key_fwd;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'(NR)) begin
                    fsm_d = ADDKEY;
`ifdef AES_DEC_KEY_CACHE_EN
                    k10_d  = key_fwd;
                    cvld_d = 1'b1;
`endif
                end
            end
            ADDKEY: begin
                state_d = state_q ^ rkey_q;
                rkey_d  = key_rev;
                cnt_d   = 4'(NR - 1);
                fsm_d   = ROUND;
            end
            ROUND: begin
                state_d = round_out;
                if (!last_rnd) begin
                    rkey_d = key_rev;
                    cnt_d  = cnt_q - 4'd1;
                end else begin
                    out_d  = round_out;
                    done_d = 1'b1;
                    fsm_d  = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rkey_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rkey_q  <= rkey_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

`ifdef AES_DEC_KEY_CACHE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lkey_q <= '0;
            k10_q  <= '0;
            cvld_q <= 1'b0;
        end else begin
            lkey_q <= lkey_d;
            k10_q  <= k10_d;
            cvld_q <= cvld_d;
        end
    end
`endif

    assign bus.out  = out_q;
    assign bus.done = done_q;
    assign bus.busy = (fsm_q != IDLE);

endmodule
